jtag_stream_engine: RTL

- Parametrised successor to the fixed 32-bit JTAG bit-shifter that sits behind the AXI-Lite JTAG register interface.
- Shifts JTAG sequences of arbitrary length, up to 2^LEN_WIDTH-1 bits, as a stream of WORD_WIDTH-bit TMS/TDI words.
- Returns TDO words on a separate stream with valid/ready flow control.
- TCK divider is set per command at runtime, and the engine pauses TCK (held low) when a stream under-runs or back-pressures.

---
 rtl/jtag_stream_engine.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/jtag_stream_engine.sv
// Streaming JTAG shifter: consumes TMS/TDI words, drives TCK/TMS/TDI with a runtime divider and
// returns captured TDO words through a single-entry holding register.
module jtag_stream_engine #(
  parameter int unsigned WordWidth = 32,
  parameter int unsigned LenWidth  = 16,
  parameter int unsigned DivWidth  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [LenWidth-1:0]  cmd_length_i,
  input  logic [DivWidth-1:0]  cmd_div_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WordWidth-1:0] in_tms_i,
  input  logic [WordWidth-1:0] in_tdi_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [WordWidth-1:0] out_tdo_o,
  output logic                 busy_o,
  output logic                 tck_o,
  output logic                 tms_o,
  output logic                 tdi_o,
  input  logic                 tdo_i
);

  localparam int unsigned IdxW = $clog2(WordWidth);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WordWidth - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StLow, StHigh, StWaitOut} state_e;

  state_e               state_q, state_d;
  logic [LenWidth-1:0]  len_q, len_d, cnt_q, cnt_d, cnt_inc;
  logic [DivWidth-1:0]  div_q, div_d, div_cnt_q, div_cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d, idx_nxt;
  logic [WordWidth-1:0] tms_w_q, tms_w_d, tdi_w_q, tdi_w_d;
  logic [WordWidth-1:0] cap_q, cap_d, cap_new;
  logic [WordWidth-1:0] out_tdo_q, out_tdo_d;
  logic                 out_valid_q, out_valid_d;
  logic                 tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
  logic                 out_free, last_bit, word_end;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    div_d       = div_q;
    div_cnt_d   = div_cnt_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    tms_w_d     = tms_w_q;
    tdi_w_d     = tdi_w_q;
    cap_d       = cap_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    out_tdo_d   = out_tdo_q;
    out_valid_d = out_valid_q & ~out_ready_i;

    // Holding register accepts a word if empty or being drained this very cycle.
    out_free = ~out_valid_q | out_ready_i;
    cap_new  = cap_q;
    cap_new[idx_q] = tdo_i;
    cnt_inc  = cnt_q + 1'b1;
    idx_nxt  = idx_q + 1'b1;
    last_bit = (cnt_inc == len_q);
    word_end = (idx_q == LastIdx);

    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          len_d = cmd_length_i;
          div_d = cmd_div_i;
          cnt_d = '0;
          if (cmd_length_i != '0) state_d = StLoad;
        end
      end
      StLoad: begin
        if (in_valid_i) begin
          tms_w_d   = in_tms_i;
          tdi_w_d   = in_tdi_i;
          idx_d     = '0;
          cap_d     = '0;
          tms_d     = in_tms_i[0];
          tdi_d     = in_tdi_i[0];
          div_cnt_d = '0;
          state_d   = StLow;
        end
      end
      StLow: begin
        if (div_cnt_q == div_q) begin
          div_cnt_d = '0;
          state_d   = StHigh;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      StHigh: begin
        if (div_cnt_q != div_q) begin
          div_cnt_d = div_cnt_q + 1'b1;
        end else begin
          div_cnt_d = '0;
          cap_d     = cap_new;
          cnt_d     = cnt_inc;
          if (!word_end && !last_bit) begin
            idx_d   = idx_nxt;
            tms_d   = tms_w_q[idx_nxt];
            tdi_d   = tdi_w_q[idx_nxt];
            state_d = StLow;
          end else if (out_free) begin
            out_tdo_d   = cap_new;
            out_valid_d = 1'b1;
            state_d     = last_bit ? StIdle : StLoad;
          end else begin
            state_d = StWaitOut;
          end
        end
      end
      StWaitOut: begin
        if (out_free) begin
          out_tdo_d   = cap_q;
          out_valid_d = 1'b1;
          state_d     = (cnt_q == len_q) ? StIdle : StLoad;
        end
      end
      default: state_d = StIdle;
    endcase

    // TCK is registered from the next state so it never glitches.
    tck_d = (state_d == StHigh);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      len_q       <= '0;
      div_q       <= '0;
      div_cnt_q   <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      tms_w_q     <= '0;
      tdi_w_q     <= '0;
      cap_q       <= '0;
      out_tdo_q   <= '0;
      out_valid_q <= 1'b0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b0;
      tdi_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      div_q       <= div_d;
      div_cnt_q   <= div_cnt_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      tms_w_q     <= tms_w_d;
      tdi_w_q     <= tdi_w_d;
      cap_q       <= cap_d;
      out_tdo_q   <= out_tdo_d;
      out_valid_q <= out_valid_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
    end
  end

  assign cmd_ready_o = (state_q == StIdle);
  assign in_ready_o  = (state_q == StLoad);
  assign busy_o      = (state_q != StIdle);
  assign out_valid_o = out_valid_q;
  assign out_tdo_o   = out_tdo_q;
  assign tck_o       = tck_q;
  assign tms_o       = tms_q;
  assign tdi_o       = tdi_q;

endmodule
